// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Purpose  : Fetch stage that reads one instruction word per request and
//            presents it with pre-split fields to decode via valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_fetch_req,
  input  logic [15:0] i_pc,
  input  logic        i_flush,
  output logic        o_busy,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  input  logic [15:0] i_mem_rddata,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [15:0] o_instr,
  output logic [4:0]  o_opcode,
  output logic [2:0]  o_rx,
  output logic [2:0]  o_ry,
  output logic [15:0] o_imm8,
  output logic [15:0] o_imm11,
  output logic        o_misaligned
);

  localparam logic [2:0] C_LAT = 3'(RD_LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic        discard_q;
  logic        busy_q;
  logic [15:0] mem_addr_q;
  logic        mem_rd_q;
  logic        valid_q;
  logic [15:0] instr_q;
  logic        mis_q;
  logic        accept_d;

  // A new fetch starts from IDLE, or straight out of HOLD when the held word
  // is consumed in the same cycle; flush always wins.
  assign accept_d = i_fetch_req && !i_flush &&
                    ((state_q == IDLE) || ((state_q == HOLD) && i_instr_ready));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      discard_q  <= 1'b0;
      busy_q     <= 1'b0;
      mem_addr_q <= 16'h0000;
      mem_rd_q   <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= 16'h0000;
      mis_q      <= 1'b0;
    end else begin
      mem_rd_q <= 1'b0;
      if (accept_d) begin
        mem_addr_q <= {i_pc[15:1], 1'b0};
        mis_q      <= i_pc[0];
        mem_rd_q   <= 1'b1;
        busy_q     <= 1'b1;
        state_q    <= REQ;
      end
      case (state_q)
        IDLE: begin
          discard_q <= 1'b0;
        end
        REQ: begin
          cnt_q   <= C_LAT;
          state_q <= WAIT;
          if (i_flush) begin
            discard_q <= 1'b1;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            // The bus read cannot be cancelled, so the word always lands.
            instr_q <= i_mem_rddata;
            if (discard_q || i_flush) begin
              discard_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end else begin
              valid_q <= 1'b1;
              state_q <= HOLD;
            end
          end else if (i_flush) begin
            discard_q <= 1'b1;
          end
        end
        HOLD: begin
          if (i_flush || i_instr_ready) begin
            valid_q <= 1'b0;
            if (!accept_d) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_busy        = busy_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_rd      = mem_rd_q;
  assign o_instr_valid = valid_q;
  assign o_instr       = instr_q;
  assign o_misaligned  = mis_q;
  assign o_opcode      = instr_q[4:0];
  assign o_rx          = instr_q[7:5];
  assign o_ry          = instr_q[10:8];
  assign o_imm8        = {{8{instr_q[15]}}, instr_q[15:8]};
  assign o_imm11       = {{5{instr_q[15]}}, instr_q[15:5]};

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch at read latencies 1 and 3.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        req   [2];
  logic [15:0] pc    [2];
  logic        flush [2];
  logic        ready [2];
  logic [15:0] rdata [2];
  logic        busy  [2];
  logic        mrd   [2];
  logic        vld   [2];
  logic        mis   [2];
  logic [15:0] maddr [2];
  logic [15:0] instr [2];
  logic [15:0] imm8  [2];
  logic [15:0] imm11 [2];
  logic [4:0]  opc   [2];
  logic [2:0]  rx    [2];
  logic [2:0]  ry    [2];

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [256];

  // Transaction-level reference: one optional fetch in flight (strobe cycle
  // and fixed latency) and one optional held word.
  int          cyc;
  int          lat    [2];
  bit          pend   [2];
  bit          held   [2];
  bit          disc   [2];
  int          s_cyc  [2];
  logic [15:0] eaddr  [2];
  logic [15:0] einstr [2];
  logic        emis   [2];

  instr_fetch #(.RD_LATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset), .i_fetch_req(req[0]), .i_pc(pc[0]),
    .i_flush(flush[0]), .o_busy(busy[0]), .o_mem_addr(maddr[0]),
    .o_mem_rd(mrd[0]), .i_mem_rddata(rdata[0]), .o_instr_valid(vld[0]),
    .i_instr_ready(ready[0]), .o_instr(instr[0]), .o_opcode(opc[0]),
    .o_rx(rx[0]), .o_ry(ry[0]), .o_imm8(imm8[0]), .o_imm11(imm11[0]),
    .o_misaligned(mis[0])
  );

  instr_fetch #(.RD_LATENCY(3)) u_dut1 (
    .clk(clk), .reset(reset), .i_fetch_req(req[1]), .i_pc(pc[1]),
    .i_flush(flush[1]), .o_busy(busy[1]), .o_mem_addr(maddr[1]),
    .o_mem_rd(mrd[1]), .i_mem_rddata(rdata[1]), .o_instr_valid(vld[1]),
    .i_instr_ready(ready[1]), .o_instr(instr[1]), .o_opcode(opc[1]),
    .o_rx(rx[1]), .o_ry(ry[1]), .o_imm8(imm8[1]), .o_imm11(imm11[1]),
    .o_misaligned(mis[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [15:0] sx(input int v, input int bits);
    int r;
    r = (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    return r[15:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0; held[k] = 0; disc[k] = 0; s_cyc[k] = 0;
      eaddr[k] = 16'h0000; einstr[k] = 16'h0000; emis[k] = 1'b0;
    end
  endtask

  task automatic check_all(input int k);
    int w;
    w = int'(einstr[k]);
    chk("mem_rd",  k, 16'(mrd[k]),  16'(pend[k] && (cyc == s_cyc[k])));
    chk("busy",    k, 16'(busy[k]), 16'(pend[k] || held[k]));
    chk("valid",   k, 16'(vld[k]),  16'(held[k]));
    chk("addr",    k, maddr[k], eaddr[k]);
    chk("instr",   k, instr[k], einstr[k]);
    chk("mis",     k, 16'(mis[k]), 16'(emis[k]));
    chk("opcode",  k, 16'(opc[k]), 16'(w % 32));
    chk("rx",      k, 16'(rx[k]),  16'((w / 32) % 8));
    chk("ry",      k, 16'(ry[k]),  16'((w / 256) % 8));
    chk("imm8",    k, imm8[k],  sx(w / 256, 8));
    chk("imm11",   k, imm11[k], sx(w / 32, 11));
  endtask

  task automatic model_update(input int k);
    if (pend[k]) begin
      if (flush[k]) disc[k] = 1;
      if (cyc == s_cyc[k] + lat[k]) begin
        einstr[k] = mem[eaddr[k][8:1]];
        pend[k]   = 0;
        held[k]   = !disc[k];
        disc[k]   = 0;
      end
    end else if (held[k]) begin
      if (flush[k]) held[k] = 0;
      else if (ready[k]) begin
        held[k] = 0;
        if (req[k]) begin
          pend[k] = 1; s_cyc[k] = cyc + 1;
          eaddr[k] = {pc[k][15:1], 1'b0}; emis[k] = pc[k][0];
        end
      end
    end else if (!flush[k] && req[k]) begin
      pend[k] = 1; s_cyc[k] = cyc + 1;
      eaddr[k] = {pc[k][15:1], 1'b0}; emis[k] = pc[k][0];
    end
  endtask

  // Memory returns the real word only in the cycle the model says it is due.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      if (pend[k] && (cyc == s_cyc[k] + lat[k])) rdata[k] = mem[eaddr[k][8:1]];
      else rdata[k] = 16'($urandom);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) model_update(k);
    cyc++;
    for (int k = 0; k < 2; k++) check_all(k);
  endtask

  task automatic set_in(input int k, input logic rq, input logic [15:0] p,
                        input logic fl, input logic rd);
    req[k] = rq; pc[k] = p; flush[k] = fl; ready[k] = rd;
  endtask

  task automatic wait_valid(input int k);
    int n;
    n = 0;
    while (!vld[k] && n < 12) begin
      step();
      n++;
    end
    chk("valid_timeout", k, 16'(vld[k]), 16'd1);
  endtask

  logic [15:0] saved;

  initial begin
    clk = 0; reset = 0; cyc = 0;
    lat[0] = 1; lat[1] = 3;
    for (int k = 0; k < 2; k++) begin
      set_in(k, 0, 16'h0000, 0, 0);
      rdata[k] = 16'h0000;
    end
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8] = 16'hA5E3;
    model_reset();
    #1;
    check_all(0); check_all(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;

    // Single fetch, latency 1, field decode of A5E3
    set_in(0, 1, 16'h0010, 0, 0); step(); set_in(0, 0, 16'h0000, 0, 0);
    chk("t1_rd", 0, 16'(mrd[0]), 16'd1);
    chk("t1_addr", 0, maddr[0], 16'h0010);
    step();
    chk("t1_rd_once", 0, 16'(mrd[0]), 16'd0);
    chk("t1_early_valid", 0, 16'(vld[0]), 16'd0);
    step();
    chk("t1_valid", 0, 16'(vld[0]), 16'd1);
    chk("t1_opcode", 0, 16'(opc[0]), 16'h0003);
    chk("t1_rx", 0, 16'(rx[0]), 16'd7);
    chk("t1_ry", 0, 16'(ry[0]), 16'd5);
    chk("t1_imm8", 0, imm8[0], 16'hFFA5);
    chk("t1_imm11", 0, imm11[0], 16'hFD2F);
    set_in(0, 0, 16'h0000, 0, 1); step();
    chk("t1_consumed", 0, 16'(vld[0]), 16'd0);

    // Back-to-back fetches with a request in the consume cycle
    set_in(0, 1, 16'h0000, 0, 1); step(); set_in(0, 0, 16'h0000, 0, 1);
    wait_valid(0);
    chk("b2b_first", 0, instr[0], mem[0]);
    set_in(0, 1, 16'h0002, 0, 1); step(); set_in(0, 0, 16'h0000, 0, 1);
    chk("b2b_rd", 0, 16'(mrd[0]), 16'd1);
    chk("b2b_busy", 0, 16'(busy[0]), 16'd1);
    wait_valid(0);
    chk("b2b_second", 0, instr[0], mem[1]);
    step();
    chk("b2b_idle", 0, 16'(busy[0]), 16'd0);

    // Stall in HOLD; requests without ready are ignored
    set_in(0, 1, 16'h0020, 0, 0); step(); set_in(0, 0, 16'h0000, 0, 0);
    wait_valid(0);
    saved = instr[0];
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1, 16'($urandom), 0, 0); step();
      chk("hold_valid", 0, 16'(vld[0]), 16'd1);
      chk("hold_stable", 0, instr[0], saved);
      chk("hold_no_rd", 0, 16'(mrd[0]), 16'd0);
    end
    set_in(0, 0, 16'h0000, 0, 1); step(); set_in(0, 0, 16'h0000, 0, 0);

    // Flush during WAIT at latency 3
    set_in(1, 1, 16'h0040, 0, 0); step(); set_in(1, 0, 16'h0000, 0, 0);
    chk("fl_rd", 1, 16'(mrd[1]), 16'd1);
    step();
    set_in(1, 0, 16'h0000, 1, 0); step(); set_in(1, 0, 16'h0000, 0, 0);
    chk("fl_busy_a", 1, 16'(busy[1]), 16'd1);
    step();
    chk("fl_busy_b", 1, 16'(busy[1]), 16'd1);
    chk("fl_novalid", 1, 16'(vld[1]), 16'd0);
    step();
    chk("fl_busy_fall", 1, 16'(busy[1]), 16'd0);
    chk("fl_novalid2", 1, 16'(vld[1]), 16'd0);
    chk("fl_data", 1, instr[1], mem[8'h20]);

    // Misaligned PC
    set_in(0, 1, 16'h0031, 0, 0); step(); set_in(0, 0, 16'h0000, 0, 0);
    chk("mis_addr", 0, maddr[0], 16'h0030);
    wait_valid(0);
    chk("mis_flag", 0, 16'(mis[0]), 16'd1);
    chk("mis_data", 0, instr[0], mem[8'h18]);
    set_in(0, 0, 16'h0000, 0, 1); step(); set_in(0, 0, 16'h0000, 0, 0);

    // Asynchronous reset mid-WAIT
    set_in(1, 1, 16'h0050, 0, 0); step(); set_in(1, 0, 16'h0000, 0, 0);
    step();
    #3 reset = 0;
    #1;
    model_reset();
    check_all(0); check_all(1);
    chk("rst_busy", 1, 16'(busy[1]), 16'd0);
    chk("rst_instr", 1, instr[1], 16'h0000);
    #2 reset = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rst_no_valid", 1, 16'(vld[1]), 16'd0);
    end

    // Randomized traffic on both latencies
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++)
        set_in(k, 1'($urandom % 2), 16'($urandom), 1'(($urandom % 8) == 0),
               1'($urandom % 2));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
